// File: rtl/encrypter_scheduler_pkg.sv
// Shared sizing and slot-state encoding for the encrypter scheduler.
package encrypter_pkg;
  localparam int NUM_ENCRYPTERS     = 4;
  localparam int ENCRYPTER_WIDTH    = 32;
  localparam int KEY_WIDTH          = 128;
  localparam int KEY_ROTATION_WIDTH = 8;
  localparam int PTR_W              = $clog2(NUM_ENCRYPTERS);
  localparam int CNT_W              = PTR_W + 1;

  typedef enum logic [1:0] {FREE, ISSUED, RUNNING, DONE} slot_state_t;
endpackage

// File: rtl/encrypter_scheduler_if.sv
// Packet stream in, per-encrypter job bus, ciphertext stream out, status.
interface encrypter_scheduler_if;
  import encrypter_pkg::*;

  logic [ENCRYPTER_WIDTH-1:0]                          in_data;
  logic                                                in_valid;
  logic                                                in_ready;
  logic [NUM_ENCRYPTERS-1:0][ENCRYPTER_WIDTH-1:0]      enc_data;
  logic [NUM_ENCRYPTERS-1:0][KEY_ROTATION_WIDTH-1:0]   enc_key_rotation;
  logic [NUM_ENCRYPTERS-1:0]                           enc_data_ready;
  logic [NUM_ENCRYPTERS-1:0]                           enc_ready;
  logic [NUM_ENCRYPTERS-1:0][ENCRYPTER_WIDTH-1:0]      enc_result;
  logic [NUM_ENCRYPTERS-1:0]                           enc_result_valid;
  logic [NUM_ENCRYPTERS-1:0]                           enc_result_ack;
  logic [ENCRYPTER_WIDTH-1:0]                          out_data;
  logic                                                out_valid;
  logic                                                out_ready;
  logic [CNT_W-1:0]                                    outstanding;
  logic                                                idle;
  logic                                                protocol_error;

  modport slave (
    input  in_data, in_valid, enc_ready, enc_result, enc_result_valid, out_ready,
    output in_ready, enc_data, enc_key_rotation, enc_data_ready, enc_result_ack,
           out_data, out_valid, outstanding, idle, protocol_error
  );

  modport master (
    output in_data, in_valid, enc_ready, enc_result, enc_result_valid, out_ready,
    input  in_ready, enc_data, enc_key_rotation, enc_data_ready, enc_result_ack,
           out_data, out_valid, outstanding, idle, protocol_error
  );
endinterface

// File: rtl/encrypter_scheduler_slot.sv
// One encrypter's job tracker: FREE -> ISSUED -> RUNNING -> DONE -> FREE.
module encrypter_slot
  import encrypter_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          accept,
  input  logic                          collect,
  input  logic [ENCRYPTER_WIDTH-1:0]    in_data,
  input  logic [KEY_ROTATION_WIDTH-1:0] rotation,
  input  logic                          enc_ready,
  input  logic                          enc_result_valid,
  input  logic [ENCRYPTER_WIDTH-1:0]    enc_result,
  output slot_state_t                   state,
  output logic [ENCRYPTER_WIDTH-1:0]    enc_data,
  output logic [KEY_ROTATION_WIDTH-1:0] enc_key_rotation,
  output logic                          enc_data_ready,
  output logic                          enc_result_ack,
  output logic [ENCRYPTER_WIDTH-1:0]    result_buf,
  output logic                          error
);
  slot_state_t state_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FREE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      FREE:    if (accept)           state_d = ISSUED;
      ISSUED:  if (!enc_ready)       state_d = RUNNING;
      RUNNING: if (enc_result_valid) state_d = DONE;
      DONE:    if (collect)          state_d = FREE;
    endcase
  end

  // Offer is a pure decode of the state register so reset drops it at once.
  assign enc_data_ready = (state == ISSUED);
  assign error          = enc_result_valid && (state != RUNNING);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enc_data         <= '0;
      enc_key_rotation <= '0;
      result_buf       <= '0;
      enc_result_ack   <= 1'b0;
    end else begin
      if (accept) begin
        enc_data         <= in_data;
        enc_key_rotation <= rotation;
      end
      if (state == RUNNING && enc_result_valid) result_buf <= enc_result;
      enc_result_ack <= (state == RUNNING) && enc_result_valid;
    end
  end
endmodule

// File: rtl/encrypter_scheduler.sv
// Round-robin dispatch of packets to the encrypter array, in-order collection.
module encrypter_scheduler
  import encrypter_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  encrypter_scheduler_if.slave bus
);
  slot_state_t                                    slot_state [NUM_ENCRYPTERS];
  logic [NUM_ENCRYPTERS-1:0][ENCRYPTER_WIDTH-1:0] result_buf;
  logic [NUM_ENCRYPTERS-1:0]                      accept_vec, collect_vec, err_vec;
  logic [PTR_W-1:0]                               dispatch_ptr, collect_ptr;
  logic [KEY_ROTATION_WIDTH-1:0]                  rotation;
  logic [CNT_W-1:0]                               outstanding_q;
  logic                                           run_q, err_q, accept, collect;

  // run_q keeps in_ready low through reset and for the release cycle.
  assign bus.in_ready       = run_q && (slot_state[dispatch_ptr] == FREE) && bus.enc_ready[dispatch_ptr];
  assign accept             = bus.in_valid && bus.in_ready;
  assign bus.out_valid      = (slot_state[collect_ptr] == DONE);
  assign bus.out_data       = result_buf[collect_ptr];
  assign collect            = bus.out_valid && bus.out_ready;
  assign bus.outstanding    = outstanding_q;
  assign bus.idle           = (outstanding_q == '0);
  assign bus.protocol_error = err_q;

  for (genvar i = 0; i < NUM_ENCRYPTERS; i++) begin : g_slot
    assign accept_vec[i]  = accept  && (dispatch_ptr == PTR_W'(i));
    assign collect_vec[i] = collect && (collect_ptr  == PTR_W'(i));

    encrypter_slot u_slot (
      .clk              (clk),
      .reset            (reset),
      .accept           (accept_vec[i]),
      .collect          (collect_vec[i]),
      .in_data          (bus.in_data),
      .rotation         (rotation),
      .enc_ready        (bus.enc_ready[i]),
      .enc_result_valid (bus.enc_result_valid[i]),
      .enc_result       (bus.enc_result[i]),
      .state            (slot_state[i]),
      .enc_data         (bus.enc_data[i]),
      .enc_key_rotation (bus.enc_key_rotation[i]),
      .enc_data_ready   (bus.enc_data_ready[i]),
      .enc_result_ack   (bus.enc_result_ack[i]),
      .result_buf       (result_buf[i]),
      .error            (err_vec[i])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q         <= 1'b0;
      dispatch_ptr  <= '0;
      collect_ptr   <= '0;
      rotation      <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (accept) begin
        dispatch_ptr <= dispatch_ptr + PTR_W'(1);
        rotation     <= (rotation == KEY_ROTATION_WIDTH'(KEY_WIDTH - 1)) ? '0
                                                                         : rotation + KEY_ROTATION_WIDTH'(1);
      end
      if (collect) collect_ptr <= collect_ptr + PTR_W'(1);
      // Accept and collect always hit different slots, so both together cancel.
      case ({accept, collect})
        2'b10:   outstanding_q <= outstanding_q + CNT_W'(1);
        2'b01:   outstanding_q <= outstanding_q - CNT_W'(1);
        default: ;
      endcase
      err_q <= err_q | (|err_vec);
    end
  end
endmodule

// File: tb/tb_encrypter_scheduler.sv
// Random/directed bench with behavioural encrypters and an in-order packet model.
module tb_encrypter_scheduler;
  import encrypter_pkg::*;
  localparam int N = NUM_ENCRYPTERS;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  encrypter_scheduler_if bus ();
  encrypter_scheduler dut (.clk(clk), .reset(reset), .bus(bus));

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] cipher(input logic [31:0] d, input logic [7:0] r);
    return (d ^ {4{r}}) + 32'h1357_9bdf;
  endfunction

  // ---------------- behavioural encrypters ----------------
  logic [N-1:0]        ready_r = '1, rv_r = '0, hold, inj;
  logic [N-1:0][31:0]  res_r = '0;
  logic [31:0]         rdata [N];
  logic [7:0]          rrot  [N];
  int                  st [N], cnt [N], cur_k [N], jobs [N], done_cnt [N];

  assign bus.enc_ready        = ready_r;
  assign bus.enc_result_valid = rv_r | inj;
  assign bus.enc_result       = res_r;

  // scheduler model state
  logic [31:0] pkt_q [$];
  int          acc_cnt = 0, out_cnt = 0;
  logic        perr_exp = 1'b0, exp_valid, live = 1'b0;

  always @(posedge clk) live = reset;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (!reset) begin
        st[i] = 0; cnt[i] = 0; jobs[i] = 0; done_cnt[i] = 0;
        ready_r[i] = 1'b1; rv_r[i] = 1'b0;
      end else begin
        chk("ack", bus.enc_result_ack[i], rv_r[i]);
        if (rv_r[i]) done_cnt[i]++;
        rv_r[i] = 1'b0;
        case (st[i])
          0: if (bus.enc_data_ready[i]) begin
               cur_k[i] = jobs[i] * N + i;
               jobs[i]++;
               if (cur_k[i] < pkt_q.size()) begin
                 chk("enc_data", bus.enc_data[i], pkt_q[cur_k[i]]);
                 chk("enc_rot", bus.enc_key_rotation[i], cur_k[i] % KEY_WIDTH);
               end else chk("enc_unexpected_job", 1, 0);
               rdata[i] = bus.enc_data[i];
               rrot[i]  = bus.enc_key_rotation[i];
               cnt[i]   = $urandom_range(0, 2);
               st[i]    = 1;
             end
          1: if (cnt[i] > 0) cnt[i]--;
             else begin ready_r[i] = 1'b0; cnt[i] = $urandom_range(0, 3); st[i] = 2; end
          2: if (cnt[i] > 0) cnt[i]--;
             else if (!hold[i]) begin
               rv_r[i] = 1'b1; res_r[i] = cipher(rdata[i], rrot[i]); st[i] = 3;
             end
          3: begin ready_r[i] = 1'b1; st[i] = 0; end
          default: st[i] = 0;
        endcase
      end
    end
  end

  // ---------------- in-order stream model ----------------
  always @(negedge clk) begin
    if (!reset) begin
      acc_cnt = 0; out_cnt = 0; pkt_q.delete(); perr_exp = 1'b0;
    end else begin
      exp_valid = (out_cnt < acc_cnt) && (done_cnt[out_cnt % N] > out_cnt / N);
      chk("outstanding", bus.outstanding, acc_cnt - out_cnt);
      chk("out_bound", bus.outstanding <= N, 1);
      chk("idle", bus.idle, acc_cnt == out_cnt);
      chk("in_ready", bus.in_ready, live && (acc_cnt - out_cnt < N) && ready_r[acc_cnt % N]);
      chk("out_valid", bus.out_valid, exp_valid);
      if (exp_valid) chk("out_data", bus.out_data, cipher(pkt_q[out_cnt], 8'(out_cnt % KEY_WIDTH)));
      chk("protocol_error", bus.protocol_error, perr_exp);
      if (bus.out_valid && bus.out_ready) out_cnt++;
      if (bus.in_valid && bus.in_ready) begin pkt_q.push_back(bus.in_data); acc_cnt++; end
      if (inj != '0) perr_exp = 1'b1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d);
    int a0;
    a0 = acc_cnt;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int t = 0; t < 300 && acc_cnt == a0; t++) begin @(negedge clk); #1; end
    if (acc_cnt == a0) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int t = 0; t < 1000 && out_cnt != acc_cnt; t++) cycles(1);
    chk("drain_done", out_cnt == acc_cnt, 1);
    cycles(2);
  endtask

  task automatic reset_values(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_outstanding"}, bus.outstanding, 0);
    chk({tag, "_idle"}, bus.idle, 1);
    chk({tag, "_perr"}, bus.protocol_error, 0);
    chk({tag, "_data_ready"}, bus.enc_data_ready, 0);
    chk({tag, "_ack"}, bus.enc_result_ack, 0);
    chk({tag, "_enc_data"}, bus.enc_data[0] | bus.enc_data[N-1], 0);
    chk({tag, "_enc_rot"}, bus.enc_key_rotation[0] | bus.enc_key_rotation[N-1], 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, o0;
    reset = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    hold = '0; inj = '0;
    cycles(3);
    reset_values("rst");
    @(negedge clk); reset = 1'b1;
    cycles(1);
    chk("post_rst_in_ready", bus.in_ready, 1);

    // four packets fill the array, results return 3,1,0,2
    hold = '1;
    for (int k = 0; k < 4; k++) send(32'hA000_0001 + k);
    bus.in_valid = 1'b1; bus.in_data = 32'hA000_0005;
    repeat (6) begin cycles(1); chk("full_in_ready", bus.in_ready, 0); end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    hold[3] = 1'b0; cycles(6);
    hold[1] = 1'b0; cycles(6);
    chk("ooo_wait_valid", bus.out_valid, 0);
    hold[0] = 1'b0; cycles(6);
    hold[2] = 1'b0;
    drain();
    chk("t1_count", out_cnt, 4);

    // downstream stall with every slot DONE
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send($urandom);
    cycles(20);
    repeat (50) begin
      cycles(1);
      chk("stall_valid", bus.out_valid, 1);
      chk("stall_data", bus.out_data, cipher(pkt_q[out_cnt], 8'(out_cnt % KEY_WIDTH)));
      chk("stall_in_ready", bus.in_ready, 0);
    end
    o0 = out_cnt;
    bus.out_ready = 1'b1;
    cycles(4);
    chk("stall_burst", out_cnt - o0, 4);
    drain();

    // random traffic across the rotation wrap
    a0 = acc_cnt;
    for (int t = 0; t < 4000 && acc_cnt < a0 + 130; t++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = $urandom;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cycles(1);
    end
    bus.in_valid = 1'b0;
    chk("random_sent", acc_cnt >= a0 + 130, 1);
    drain();

    // stray result on an idle slot
    inj[2] = 1'b1; cycles(1); inj = '0;
    cycles(5);
    chk("stray_perr", bus.protocol_error, 1);
    chk("stray_no_valid", bus.out_valid, 0);
    send($urandom); send($urandom);
    drain();
    chk("perr_sticky", bus.protocol_error, 1);

    // reset with jobs in flight
    hold = '1;
    for (int k = 0; k < 3; k++) send($urandom);
    cycles(8);
    chk("inflight_outstanding", bus.outstanding, 3);
    @(negedge clk); #2; reset = 1'b0; #1;
    reset_values("midrst");
    hold = '0;
    cycles(2);
    @(negedge clk); #2; reset = 1'b1;
    cycles(1);
    send(32'hB000_0001);
    chk("first_dr", bus.enc_data_ready, 1);
    chk("first_data", bus.enc_data[0], 32'hB000_0001);
    chk("first_rot", bus.enc_key_rotation[0], 0);
    drain();
    chk("final_perr", bus.protocol_error, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/encrypter_scheduler.md
# encrypter_scheduler

Round-robin job scheduler between the QSPI packet front end and the encrypter array. Accepts one plaintext packet per valid/ready transfer, dispatches it with the current key rotation to the next encrypter in strict rotation, tracks each encrypter's job through issue/run/done, and returns ciphertext to a single downstream stream in dispatch order. Owns the per-encrypter data_ready/ready handshake that the front end previously drove directly.

## Interface
- NUM_ENCRYPTERS, 4, encrypter count (power of two, ≥2)
- ENCRYPTER_WIDTH, 32, packet width in bits
- KEY_WIDTH, 128, key length; rotation wraps here
- KEY_ROTATION_WIDTH, 8, rotation field width (≥ clog2(KEY_WIDTH))
- clk  in  1  sole clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- in_data  in  ENCRYPTER_WIDTH  plaintext packet
- in_valid  in  1  packet present
- in_ready  out  1  packet accepted when in_valid && in_ready
- enc_data  out  [NUM_ENCRYPTERS][ENCRYPTER_WIDTH]  per-encrypter packet bus
- enc_key_rotation  out  [NUM_ENCRYPTERS][KEY_ROTATION_WIDTH]  per-encrypter rotation
- enc_data_ready  out  NUM_ENCRYPTERS  job offered to encrypter i
- enc_ready  in  NUM_ENCRYPTERS  encrypter idle; falling edge while offered = acknowledge
- enc_result  in  [NUM_ENCRYPTERS][ENCRYPTER_WIDTH]  ciphertext
- enc_result_valid  in  NUM_ENCRYPTERS  ciphertext present
- enc_result_ack  out  NUM_ENCRYPTERS  one-cycle capture pulse
- out_data  out  ENCRYPTER_WIDTH  ciphertext, dispatch order
- out_valid / out_ready  out / in  1  downstream valid/ready
- outstanding  out  clog2(NUM_ENCRYPTERS)+1  slots not FREE
- idle  out  1  outstanding == 0
- protocol_error  out  1  sticky error flag

## Operation
- Per-slot FSM: FREE → ISSUED → RUNNING → DONE → FREE.
- dispatch_ptr, collect_ptr: wrap modulo NUM_ENCRYPTERS; increment only on their transfer.
- in_ready = slot[dispatch_ptr]==FREE && enc_ready[dispatch_ptr] (registered state only).
- Accept: register in_data → enc_data[ptr], rotation → enc_key_rotation[ptr], enc_data_ready[ptr]←1, slot ISSUED, rotation←rotation+1 (KEY_WIDTH-1 → 0), dispatch_ptr++.
- ISSUED: enc_ready[i] sampled low → enc_data_ready[i]←0, RUNNING. enc_data/rotation held until next dispatch to i.
- RUNNING: enc_result_valid[i] → capture into result_buf[i], enc_result_ack[i] high one cycle, DONE.
- out_valid = slot[collect_ptr]==DONE; out_data = result_buf[collect_ptr]; transfer → FREE, collect_ptr++.
- No strict ordering shortcut: later slots may reach DONE first and wait.
- protocol_error set (sticky until reset) on: enc_result_valid[i] when slot i not RUNNING (result ignored, no ack); enc_ready[i] low while slot FREE is not an error (just blocks dispatch).

## Timing
- Reset values: in_ready 0 during reset, 1 first cycle after if enc_ready[0]; enc_* outputs 0; out_valid 0; outstanding 0; idle 1; protocol_error 0; rotation 0; both pointers 0.
- Accept at edge t → enc_data_ready high from t+1.
- enc_ready low sampled at edge a → enc_data_ready low from a+1.
- enc_result_valid sampled at edge r → enc_result_ack pulse in cycle r+1; out_valid by r+1 if slot is collect_ptr.
- Slot freed by output transfer at edge f is dispatchable from f+1 (no same-edge reuse).
- Simultaneous accept and output transfer on different slots: both occur; outstanding unchanged.
- All slots busy: in_ready 0 until collect frees slot[dispatch_ptr].
- out_ready held low: DONE slots retained indefinitely, no data loss.
- Reset mid-operation: everything to reset values in-flight jobs dropped; enc_data_ready deasserts asynchronously.

## Structure
- Package encrypter_pkg: NUM_ENCRYPTERS, ENCRYPTER_WIDTH, KEY_WIDTH, KEY_ROTATION_WIDTH, slot_state_t enum (FREE/ISSUED/RUNNING/DONE).
- Sub-module encrypter_slot: one per encrypter (generate loop); holds slot FSM, enc_data/rotation regs, result_buf, ack pulse, error detect. Top holds pointers, rotation counter, outstanding counter, output mux.

## Test plan
- Reset, enc_ready all 1, send 0xA0000001..0xA0000004 -> each goes to encrypter 0..3 with rotation 0..3; in_ready 0 on fifth packet until first output transfer.
- Encrypters return results in order 3,1,0,2 -> out_data emitted in order 0,1,2,3; each enc_result_ack exactly one cycle, one cycle after its result_valid.
- 130 packets with immediate ack/result -> rotation sequence 0..127,0,1; outstanding never exceeds 4.
- out_ready low for 50 cycles with all slots DONE -> out_valid held, out_data stable, in_ready 0; release -> four transfers in consecutive cycles.
- enc_result_valid[2] pulsed while slot 2 FREE -> protocol_error 1, no ack, stays 1 until reset.
- Assert reset with 3 jobs RUNNING -> all outputs to reset values immediately; first post-reset packet goes to encrypter 0 with rotation 0.
